fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch queue between the PC generator and decode. Accepts fetch addresses from the PC stage, issues them to instruction memory over a request/grant bus, and collects in-order read responses. Responses are held in a small FIFO of {pc, instr} pairs and presented to decode with a valid/ready handshake. A flush input discards queued entries and drops in-flight responses whenever the control unit redirects fetch on a jump or branch.

## Interface
- DEPTH, 4: FIFO entries and maximum outstanding-plus-queued fetches; power of two, at least 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_addr  in  32  address of the next instruction from the PC stage.
- fetch_valid  in  1  fetch_addr is valid.
- fetch_ready  out  1  request accepted this cycle; the PC stage advances only when fetch_valid && fetch_ready.
- imem_req  out  1  memory request.
- imem_addr  out  32  request address; equals fetch_addr, combinational.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read response valid.
- imem_rdata  in  32  read response data.
- flush  in  1  redirect; discard all queued and in-flight fetches.
- dec_valid  out  1  FIFO head is valid.
- dec_ready  in  1  decode consumes the head.
- dec_instr  out  32  head instruction word.
- dec_pc  out  32  head instruction address.

## Operation
- **Credit:**
  - credit = (outstanding + count) < DEPTH.
  - Uses registered values only. A pop in the same cycle does not free credit until the next cycle.
- **Request path:**
  - imem_req = fetch_valid && credit && !flush.
  - fetch_ready = imem_req && imem_gnt.
  - An accepted request increments outstanding and pushes fetch_addr into a PC tag queue of DEPTH entries.
  - No alignment check; imem_addr[1:0] is passed through unchanged.
- **Response path:**
  - imem_rvalid with discard == 0: pop the PC tag, then push {tag, imem_rdata} into the FIFO. Decrement outstanding.
  - imem_rvalid with discard > 0: drop the response, pop the tag, decrement both outstanding and discard.
  - Responses arrive in order, at least 1 cycle after grant. imem_rvalid with outstanding == 0 is a protocol violation; it is ignored and outstanding stays 0.
- **Decode path:**
  - dec_valid = (count != 0).
  - dec_instr and dec_pc come from the head entry, driven directly from FIFO storage.
  - Pop when dec_valid && dec_ready.
- **Flush cycle:**
  - count and the read/write pointers go to 0.
  - discard <= outstanding − (imem_rvalid ? 1 : 0); the response arriving in the flush cycle is also dropped.
  - No request is issued and no pop is reported; dec_ready is ignored.
  - PC tags of discarded fetches stay in the tag queue and are popped as their responses drain.
- **Overflow:** impossible by construction, because credit reserves a slot for every outstanding fetch. Push and pop in the same cycle leave count unchanged.
- **Widths:**
  - outstanding, discard and count are log2(DEPTH)+1 bits, saturating at 0 on decrement.
  - Pointers are log2(DEPTH) bits and wrap naturally.

## Timing
- **Reset values:**
  - Registers: count, outstanding, discard and all pointers = 0.
  - Outputs: dec_valid = 0, imem_req = 0, fetch_ready = 0.
  - dec_instr and dec_pc = 0; storage is cleared on reset.
- **Latency:** imem_rvalid in cycle N sets dec_valid in cycle N+1. There is no bypass from imem_rdata to dec_instr.
- **Throughput:** with 1-cycle memory latency, continuous grant and dec_ready held 1, one instruction per cycle is sustained after a 2-cycle fill.
- **Reset mid-operation:** all state clears in the reset cycle. Responses arriving after reset with outstanding == 0 are ignored.
- **Flush while discard > 0:** discard reloads from the current outstanding count, minus the response arriving that cycle.

## Test plan
- **Reset values:** assert rst for 2 cycles with fetch_valid = 1. dec_valid, imem_req and fetch_ready are 0 during reset, and all counters read 0 after release.
- **Single fetch:**
  - Stimulus: fetch_addr = 0x0000_0000, gnt = 1 in cycle 1, rvalid with rdata = 0x0000_0013 in cycle 2.
  - Response: dec_valid = 1 in cycle 3 with dec_pc = 0 and dec_instr = 0x13. Entry pops when dec_ready = 1.
- **Streaming:** addresses 0, 4, 8, 12, 16, 1-cycle memory, dec_ready = 1. One dec_valid per cycle from cycle 3, dec_pc sequence 0, 4, 8, 12, 16.
- **Back-pressure:** DEPTH = 4, dec_ready = 0, continuous grant. Exactly 4 requests accepted, then imem_req = 0. After one pop, the next request issues one cycle later.
- **Flush with outstanding fetches:**
  - Stimulus: 3 requests outstanding (memory latency 4) and 1 entry queued, then flush asserted with no rvalid that cycle.
  - Response: dec_valid = 0 the next cycle, and the next 3 responses are dropped. A new fetch at 0x100 issued after the flush is delivered with dec_pc = 0x100.
- **Flush coinciding with rvalid:** outstanding = 2, flush and imem_rvalid in the same cycle. discard = 1, exactly one later response is dropped, and count stays 0.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues PC-stage fetches to imem, tags in-order responses
// with their PC and buffers {pc, instr} for decode. Flush drops queued and in-flight work.
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_addr,
    input  logic        fetch_valid,
    output logic        fetch_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        flush,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = CW + 1;

    logic [CW-1:0] outstanding, discard, count;
    logic [AW-1:0] wptr, rptr, tag_wptr, tag_rptr;
    logic [DEPTH-1:0][31:0] tag_q, fifo_pc, fifo_instr;

    logic [OW-1:0] occ;
    logic credit, accept, rsp, push, pop;

    // Credit counts in-flight fetches as occupied slots, so a response always has room.
    always_comb begin
        occ         = {1'b0, outstanding} + {1'b0, count};
        credit      = occ < OW'(DEPTH);
        imem_req    = fetch_valid && credit && !flush && !rst;
        fetch_ready = imem_req && imem_gnt;
        accept      = fetch_ready;
        rsp         = imem_rvalid && (outstanding != '0) && !rst;
        push        = rsp && (discard == '0) && !flush;
        dec_valid   = (count != '0) && !rst;
        pop         = dec_valid && dec_ready && !flush;
    end

    assign imem_addr = fetch_addr;
    assign dec_pc    = fifo_pc[rptr];
    assign dec_instr = fifo_instr[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            wptr        <= '0;
            rptr        <= '0;
            tag_wptr    <= '0;
            tag_rptr    <= '0;
            tag_q       <= '0;
            fifo_pc     <= '0;
            fifo_instr  <= '0;
        end else begin
            if (accept) begin
                tag_q[tag_wptr] <= fetch_addr;
                tag_wptr        <= tag_wptr + AW'(1);
            end
            // Tags of discarded fetches are still popped so the queue stays aligned.
            if (rsp)
                tag_rptr <= tag_rptr + AW'(1);

            if (accept && !rsp)
                outstanding <= outstanding + CW'(1);
            else if (!accept && rsp)
                outstanding <= outstanding - CW'(1);

            if (flush) begin
                discard <= outstanding - CW'(rsp);
                count   <= '0;
                wptr    <= '0;
                rptr    <= '0;
            end else begin
                if (rsp && discard != '0)
                    discard <= discard - CW'(1);
                if (push) begin
                    fifo_pc[wptr]    <= tag_q[tag_rptr];
                    fifo_instr[wptr] <= imem_rdata;
                    wptr             <= wptr + AW'(1);
                end
                if (pop)
                    rptr <= rptr + AW'(1);
                if (push && !pop)
                    count <= count + CW'(1);
                else if (!push && pop)
                    count <= count - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: in-order memory model plus a decode-side scoreboard.
module tb_fetch_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_addr;
    logic        fetch_valid;
    logic        fetch_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        flush;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .fetch_addr(fetch_addr), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .flush(flush),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc)
    );

    int n_chk = 0, n_pass = 0, cyc = 0, lat = 1;
    logic force_rv = 1'b0;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] exp_pc[$], exp_instr[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    // Memory returns addr + 0x13 as the instruction word.
    task automatic expect_fetch(input logic [31:0] pc);
        exp_pc.push_back(pc);
        exp_instr.push_back(pc + 32'h13);
    endtask

    // Called at a falling edge after inputs are set: drive the response, then log a grant.
    task automatic step();
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend_addr[0] + 32'h13;
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            imem_rvalid = force_rv;
            imem_rdata  = 32'hdead_beef;
        end
        #1;
        if (fetch_ready) begin
            pend_addr.push_back(imem_addr);
            pend_due.push_back(cyc + lat);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    // Scoreboard monitor: every reported decode handshake must match the next expected entry.
    always @(negedge clk) begin
        #2;
        if (!rst && dec_valid && dec_ready && !flush) begin
            if (exp_pc.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_pop: got pc %h expected no entry", dec_pc);
            end else begin
                chk("dec_pc", dec_pc, exp_pc.pop_front());
                chk("dec_instr", dec_instr, exp_instr.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1; fetch_valid = 1'b1; fetch_addr = '0; imem_gnt = 1'b1;
        imem_rvalid = 1'b0; imem_rdata = '0; flush = 1'b0; dec_ready = 1'b0;

        // Reset held two cycles with fetch_valid high
        repeat (2) begin
            @(negedge clk); #1;
            chk1("rst_imem_req", imem_req, 1'b0);
            chk1("rst_fetch_ready", fetch_ready, 1'b0);
            chk1("rst_dec_valid", dec_valid, 1'b0);
        end
        rst = 1'b0; fetch_valid = 1'b0;
        chk("rst_count", 32'(dut.count), 0);
        chk("rst_outstanding", 32'(dut.outstanding), 0);
        chk("rst_discard", 32'(dut.discard), 0);
        chk("rst_dec_pc", dec_pc, 0);
        chk("rst_dec_instr", dec_instr, 0);
        nxt();

        // Single fetch
        fetch_valid = 1'b1; fetch_addr = 32'h0; lat = 1; expect_fetch(32'h0);
        step(); chk1("single_accept", fetch_ready, 1'b1); nxt();
        fetch_valid = 1'b0;
        step(); chk1("single_no_bypass", dec_valid, 1'b0); nxt();
        dec_ready = 1'b1;
        step(); chk1("single_valid", dec_valid, 1'b1); nxt();
        step(); chk1("single_popped", dec_valid, 1'b0); nxt();

        // Streaming 0,4,8,12,16 with 1-cycle memory
        for (int k = 0; k < 8; k++) begin
            fetch_valid = (k < 5);
            fetch_addr  = 32'(4 * k);
            if (k < 5) expect_fetch(32'(4 * k));
            step();
            chk1("stream_valid", dec_valid, (k >= 2 && k <= 6));
            if (k < 5) chk1("stream_accept", fetch_ready, 1'b1);
            nxt();
        end

        // Back-pressure: decode stalled, exactly DEPTH fetches accepted
        dec_ready = 1'b0; fetch_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            fetch_addr = 32'h200 + 32'(4 * k);
            step();
            chk1("bp_accept", fetch_ready, k < 4);
            chk1("bp_req", imem_req, k < 4);
            if (k < 4) expect_fetch(fetch_addr);
            nxt();
        end
        fetch_addr = 32'h210; dec_ready = 1'b1;
        step(); chk1("bp_req_pop_cycle", imem_req, 1'b0); nxt();
        dec_ready = 1'b0;
        step(); chk1("bp_req_after_pop", imem_req, 1'b1); chk1("bp_accept_after_pop", fetch_ready, 1'b1);
        expect_fetch(32'h210); nxt();
        fetch_valid = 1'b0; dec_ready = 1'b1;
        repeat (7) begin step(); nxt(); end
        step(); chk1("bp_drained", dec_valid, 1'b0); nxt();

        // Flush with 3 outstanding (latency 4) and 1 queued
        dec_ready = 1'b0; fetch_valid = 1'b1; lat = 1; fetch_addr = 32'h300;
        step(); chk1("fl_acc0", fetch_ready, 1'b1); nxt();
        lat = 4;
        for (int k = 1; k < 4; k++) begin
            fetch_addr = 32'h300 + 32'(4 * k);
            step(); chk1("fl_acc", fetch_ready, 1'b1); nxt();
        end
        flush = 1'b1;
        step(); chk1("fl_req_blocked", imem_req, 1'b0); chk1("fl_queued_before", dec_valid, 1'b1); nxt();
        flush = 1'b0; fetch_valid = 1'b0; dec_ready = 1'b1; lat = 1;
        step(); chk1("fl_dec_valid_cleared", dec_valid, 1'b0); chk("fl_discard", 32'(dut.discard), 3); nxt();
        repeat (3) begin step(); chk1("fl_dropped", dec_valid, 1'b0); nxt(); end
        chk("fl_discard_done", 32'(dut.discard), 0);
        fetch_valid = 1'b1; fetch_addr = 32'h100; expect_fetch(32'h100);
        step(); chk1("fl_new_accept", fetch_ready, 1'b1); nxt();
        fetch_valid = 1'b0;
        step(); nxt();
        step(); chk1("fl_new_valid", dec_valid, 1'b1); nxt();

        // Flush coinciding with rvalid, outstanding = 2
        lat = 2; fetch_valid = 1'b1; fetch_addr = 32'h400;
        step(); chk1("flc_acc0", fetch_ready, 1'b1); nxt();
        fetch_addr = 32'h404;
        step(); chk1("flc_acc1", fetch_ready, 1'b1); nxt();
        fetch_valid = 1'b0; flush = 1'b1;
        step(); nxt();
        flush = 1'b0;
        step(); chk("flc_discard", 32'(dut.discard), 1); chk("flc_count", 32'(dut.count), 0); nxt();
        step();
        chk("flc_count_after", 32'(dut.count), 0);
        chk("flc_outstanding", 32'(dut.outstanding), 0);
        chk1("flc_dec_valid", dec_valid, 1'b0);
        nxt();

        // Spurious rvalid with nothing outstanding
        force_rv = 1'b1;
        step(); nxt();
        force_rv = 1'b0;
        step(); chk("spur_outstanding", 32'(dut.outstanding), 0); chk1("spur_valid", dec_valid, 1'b0); nxt();

        // Reset mid-operation; the late response must be ignored
        lat = 2; fetch_valid = 1'b1; fetch_addr = 32'h500;
        step(); chk1("mrst_accept", fetch_ready, 1'b1); nxt();
        fetch_valid = 1'b0; rst = 1'b1;
        step(); nxt();
        rst = 1'b0;
        step(); nxt();
        step(); chk1("mrst_valid", dec_valid, 1'b0); chk("mrst_outstanding", 32'(dut.outstanding), 0); nxt();

        chk("sb_empty", 32'(exp_pc.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
